// File: rtl/pipe_stage_reg_if.sv
// Stage-to-stage link for pipe_stage_reg: valid/ready handshake on both sides,
// flush, and the stall counter (clear input and count output).
interface pipe_stage_reg_if #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              clr_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  // Surrounding pipeline side: drives upstream entry and downstream ready.
  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready, clr_cnt,
    input  in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );

  // Register block side.
  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready, clr_cnt,
    output in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, flush,
// optional two-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SKID   = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_stage_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              out_valid_c;
  logic              accept_c;
  logic              issue_c;

  assign out_valid_c = (state_q != ST_EMPTY);

  // rdy_q also keeps in_ready low through reset and until the first edge after release.
  if (SKID != 0) begin : g_skid
    assign bus.in_ready = rdy_q;
  end else begin : g_noskid
    assign bus.in_ready = rdy_q & (bus.out_ready | ~out_valid_c);
  end

  assign accept_c      = bus.in_valid & bus.in_ready;
  assign issue_c       = out_valid_c & bus.out_ready;
  assign bus.out_valid = out_valid_c;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.out_data  = main_data_q;
  assign bus.stall_cnt = cnt_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    cnt_d       = cnt_q;

    // Flush drops held and incoming entries; a concurrent issue has already been sampled.
    if (bus.flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept_c && issue_c) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end else if (accept_c) begin
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
            state_d     = ST_TWO;
          end else if (issue_c) begin
            main_ctrl_d = '0;
            state_d     = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (issue_c) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            state_d     = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    rdy_d = (state_d != ST_TWO);

    if (bus.clr_cnt) begin
      cnt_d = '0;
    end else if (out_valid_c && !bus.out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      rdy_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      rdy_q       <= rdy_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=0/1 streaming, a table-driven
// backpressure/flush sequence, reset mid-stall and counter saturation.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(32), .CNT_W(16)) bus0 ();
  pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(32), .CNT_W(16)) bus1 ();
  pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(32), .CNT_W(4))  bus2 ();

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .SKID(0), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .SKID(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .SKID(1), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    logic        iv;
    logic [15:0] ctrl;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [15:0] e_ctrl;
    logic        e_irdy;
    logic [31:0] e_data;
    logic [15:0] e_cnt;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[16];
  logic [15:0] issued[$];
  logic [15:0] exp_issued[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [15:0] c, logic ordy, logic fl,
                              logic eov, logic [15:0] ectrl, logic eirdy,
                              logic [31:0] edata, logic [15:0] ecnt);
    vec_t v;
    v.iv = iv; v.ctrl = c; v.ordy = ordy; v.fl = fl;
    v.e_ov = eov; v.e_ctrl = ectrl; v.e_irdy = eirdy; v.e_data = edata; v.e_cnt = ecnt;
    return v;
  endfunction

  initial begin
    // Expected values are the pre-edge outputs seen with that row's inputs applied.
    tbl[0]  = mk(1, 16'h0011, 0, 0,  0, 16'h0000, 1, 32'hD000_0008, 0);
    tbl[1]  = mk(1, 16'h0012, 0, 0,  1, 16'h0011, 1, 32'hDA7A_0011, 0);
    tbl[2]  = mk(1, 16'h0013, 0, 0,  1, 16'h0011, 0, 32'hDA7A_0011, 1);
    tbl[3]  = mk(1, 16'h0013, 0, 0,  1, 16'h0011, 0, 32'hDA7A_0011, 2);
    tbl[4]  = mk(1, 16'h0013, 1, 0,  1, 16'h0011, 0, 32'hDA7A_0011, 3);
    tbl[5]  = mk(1, 16'h0013, 1, 0,  1, 16'h0012, 1, 32'hDA7A_0012, 3);
    tbl[6]  = mk(0, 16'h0000, 1, 0,  1, 16'h0013, 1, 32'hDA7A_0013, 3);
    tbl[7]  = mk(0, 16'h0000, 0, 0,  0, 16'h0000, 1, 32'hDA7A_0013, 3);
    tbl[8]  = mk(1, 16'h0021, 0, 0,  0, 16'h0000, 1, 32'hDA7A_0013, 3);
    tbl[9]  = mk(1, 16'h0022, 0, 0,  1, 16'h0021, 1, 32'hDA7A_0021, 3);
    tbl[10] = mk(1, 16'hBEEF, 0, 1,  1, 16'h0021, 0, 32'hDA7A_0021, 4);
    tbl[11] = mk(0, 16'h0000, 0, 0,  0, 16'h0000, 1, 32'hDA7A_0021, 5);
    tbl[12] = mk(0, 16'h0000, 1, 0,  0, 16'h0000, 1, 32'hDA7A_0021, 5);
    tbl[13] = mk(1, 16'h0031, 1, 0,  0, 16'h0000, 1, 32'hDA7A_0021, 5);
    tbl[14] = mk(1, 16'h0032, 1, 1,  1, 16'h0031, 1, 32'hDA7A_0031, 5);
    tbl[15] = mk(0, 16'h0000, 1, 0,  0, 16'h0000, 1, 32'hDA7A_0031, 5);
    exp_issued[0] = 16'h0011; exp_issued[1] = 16'h0012;
    exp_issued[2] = 16'h0013; exp_issued[3] = 16'h0031;

    bus0.flush = 0; bus0.in_valid = 0; bus0.in_ctrl = '0; bus0.in_data = '0; bus0.out_ready = 0; bus0.clr_cnt = 0;
    bus1.flush = 0; bus1.in_valid = 0; bus1.in_ctrl = '0; bus1.in_data = '0; bus1.out_ready = 0; bus1.clr_cnt = 0;
    bus2.flush = 0; bus2.in_valid = 0; bus2.in_ctrl = '0; bus2.in_data = '0; bus2.out_ready = 0; bus2.clr_cnt = 0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_in_ready0", 64'(bus0.in_ready), 0);
    chk("rst_in_ready1", 64'(bus1.in_ready), 0);
    chk("rst_out_valid1", 64'(bus1.out_valid), 0);
    chk("rst_out_ctrl1", 64'(bus1.out_ctrl), 0);
    chk("rst_out_data1", 64'(bus1.out_data), 0);
    chk("rst_cnt1", 64'(bus1.stall_cnt), 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rel_in_ready0_pre_edge", 64'(bus0.in_ready), 0);
    chk("rel_in_ready1_pre_edge", 64'(bus1.in_ready), 0);

    // Streaming 8 entries through both SKID variants with out_ready held high
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus0.in_valid = (k < 8); bus1.in_valid = (k < 8);
      bus0.in_ctrl = 16'(k + 1); bus1.in_ctrl = 16'(k + 1);
      bus0.in_data = 32'hD000_0000 + 32'(k + 1); bus1.in_data = 32'hD000_0000 + 32'(k + 1);
      bus0.out_ready = 1; bus1.out_ready = 1;
      #1;
      chk($sformatf("stream0_in_ready[%0d]", k), 64'(bus0.in_ready), 1);
      chk($sformatf("stream1_in_ready[%0d]", k), 64'(bus1.in_ready), 1);
      chk($sformatf("stream0_out_valid[%0d]", k), 64'(bus0.out_valid), 64'(k >= 1 && k <= 8));
      chk($sformatf("stream1_out_valid[%0d]", k), 64'(bus1.out_valid), 64'(k >= 1 && k <= 8));
      chk($sformatf("stream0_out_ctrl[%0d]", k), 64'(bus0.out_ctrl), (k >= 1 && k <= 8) ? 64'(k) : 64'd0);
      chk($sformatf("stream1_out_ctrl[%0d]", k), 64'(bus1.out_ctrl), (k >= 1 && k <= 8) ? 64'(k) : 64'd0);
    end
    chk("stream0_data_hold", 64'(bus0.out_data), 64'h0000_0000_D000_0008);
    chk("stream1_data_hold", 64'(bus1.out_data), 64'h0000_0000_D000_0008);
    chk("stream0_cnt", 64'(bus0.stall_cnt), 0);
    chk("stream1_cnt", 64'(bus1.stall_cnt), 0);

    // Table: backpressure into TWO, flush in TWO, flush with a completing issue
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      bus1.in_valid  = tbl[r].iv;
      bus1.in_ctrl   = tbl[r].ctrl;
      bus1.in_data   = {16'hDA7A, tbl[r].ctrl};
      bus1.out_ready = tbl[r].ordy;
      bus1.flush     = tbl[r].fl;
      #1;
      chk($sformatf("tbl_out_valid[%0d]", r), 64'(bus1.out_valid), 64'(tbl[r].e_ov));
      chk($sformatf("tbl_out_ctrl[%0d]", r), 64'(bus1.out_ctrl), 64'(tbl[r].e_ctrl));
      chk($sformatf("tbl_in_ready[%0d]", r), 64'(bus1.in_ready), 64'(tbl[r].e_irdy));
      chk($sformatf("tbl_out_data[%0d]", r), 64'(bus1.out_data), 64'(tbl[r].e_data));
      chk($sformatf("tbl_cnt[%0d]", r), 64'(bus1.stall_cnt), 64'(tbl[r].e_cnt));
      if (bus1.out_valid && bus1.out_ready) issued.push_back(bus1.out_ctrl);
    end
    bus1.flush = 0;
    chk("issued_count", 64'(issued.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < issued.size()) chk($sformatf("issued[%0d]", i), 64'(issued[i]), 64'(exp_issued[i]));
      else chk($sformatf("issued[%0d]", i), 64'hDEAD, 64'(exp_issued[i]));
    end

    // Reset asserted between edges while in state TWO
    @(negedge clk);
    bus1.in_valid = 1; bus1.in_ctrl = 16'h0041; bus1.in_data = 32'hDA7A_0041; bus1.out_ready = 0;
    @(negedge clk);
    bus1.in_ctrl = 16'h0042; bus1.in_data = 32'hDA7A_0042;
    @(negedge clk);
    bus1.in_valid = 0;
    #1;
    chk("two_out_valid", 64'(bus1.out_valid), 1);
    chk("two_in_ready", 64'(bus1.in_ready), 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst_out_valid", 64'(bus1.out_valid), 0);
    chk("arst_out_ctrl", 64'(bus1.out_ctrl), 0);
    chk("arst_out_data", 64'(bus1.out_data), 0);
    chk("arst_in_ready", 64'(bus1.in_ready), 0);
    chk("arst_cnt", 64'(bus1.stall_cnt), 0);
    @(negedge clk); #1;
    chk("arst_hold_in_ready", 64'(bus1.in_ready), 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("arst_rel_in_ready_pre_edge", 64'(bus1.in_ready), 0);
    @(negedge clk); #1;
    chk("arst_rel_in_ready", 64'(bus1.in_ready), 1);
    chk("arst_rel_out_valid", 64'(bus1.out_valid), 0);

    // Stall counter saturation at 15 and clear while stalled (CNT_W=4)
    @(negedge clk);
    bus2.in_valid = 1; bus2.in_ctrl = 16'h0055; bus2.in_data = 32'h5555_0055; bus2.out_ready = 0;
    @(negedge clk);
    bus2.in_valid = 0;
    #1;
    chk("cnt_held_valid", 64'(bus2.out_valid), 1);
    for (int i = 0; i <= 20; i++) begin
      chk($sformatf("cnt_sat[%0d]", i), 64'(bus2.stall_cnt), 64'((i > 15) ? 15 : i));
      @(negedge clk); #1;
    end
    chk("cnt_sat_final", 64'(bus2.stall_cnt), 15);
    bus2.clr_cnt = 1;
    @(negedge clk);
    bus2.clr_cnt = 0;
    #1;
    chk("cnt_clr", 64'(bus2.stall_cnt), 0);
    @(negedge clk); #1;
    chk("cnt_resume1", 64'(bus2.stall_cnt), 1);
    @(negedge clk); #1;
    chk("cnt_resume2", 64'(bus2.stall_cnt), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
